// File: rtl/ext_rst_seq_pkg.sv
// ext_rst_seq_pkg
//   Shared definitions for the external reset pulse sequencer: FSM state
//   encoding, register map addresses and CTRL/STATUS bit positions.
package ext_rst_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_WIDTH   = 2'd1;
  localparam logic [1:0] ADDR_HOLDOFF = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  localparam int CTRL_START     = 0;
  localparam int CTRL_ABORT     = 1;
  localparam int CTRL_MAN_LEVEL = 2;
  localparam int CTRL_MAN_MODE  = 3;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;
  localparam int STAT_IRQ_EN   = 2;
  localparam int STAT_PCNT_LSB = 8;
  localparam int STAT_PCNT_MSB = 15;

endpackage

// File: rtl/ext_rst_seq_down_counter.sv
// ext_rst_seq_down_counter
//   Load/enable down counter used to time both the ASSERT and HOLDOFF phases.
//   Ports:
//     i_clk       system clock
//     i_reset     synchronous active-high reset
//     i_load      load i_load_val (has priority over i_en)
//     i_load_val  value to load
//     i_en        decrement enable; the counter stops at 0
//     o_tc        terminal count: high during the last cycle of a loaded duration
module ext_rst_seq_down_counter
  import ext_rst_seq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // A load of N makes the count read N..1 over N cycles; the cycle showing 1 is the last.
  assign o_tc = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/ext_rst_pulse_sequencer.sv
// ext_rst_pulse_sequencer
//   Avalon-MM slave driving the external reset line with a timed pulse of
//   max(WIDTH,1) cycles followed by HOLDOFF busy cycles, plus a manual
//   level-override mode.
//   Optional feature macro: EXT_RST_SEQ_IRQ_EN adds the irq port and the
//   irq_en flop (STATUS b2).
//   Ports:
//     i_clk         system clock
//     i_reset       synchronous active-high reset
//     i_address     register select (0 CTRL, 1 WIDTH, 2 HOLDOFF, 3 STATUS)
//     i_chipselect  slave select
//     i_write_n     active-low write strobe
//     i_writedata   write data
//     o_readdata    read data, combinational from i_address
//     o_out_port    external reset line (polarity set by ACTIVE_HIGH)
//     o_busy        high in ASSERT or HOLDOFF
//     o_irq         done interrupt (EXT_RST_SEQ_IRQ_EN builds only)
//
//   state   | meaning
//   --------+-------------------------------------------------
//   IDLE    | line inactive, or following MAN_LEVEL in manual mode
//   ASSERT  | line active, counting the latched width
//   HOLDOFF | line inactive, still busy, counting the latched hold-off
module ext_rst_pulse_sequencer
  import ext_rst_seq_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int DEFAULT_WIDTH = 100,
  parameter bit ACTIVE_HIGH   = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [1:0]  i_address,
  input  logic        i_chipselect,
  input  logic        i_write_n,
  input  logic [31:0] i_writedata,
  output logic [31:0] o_readdata,
  output logic        o_out_port,
`ifdef EXT_RST_SEQ_IRQ_EN
  output logic        o_irq,
`endif
  output logic        o_busy
);

  localparam logic OUT_ACT   = ACTIVE_HIGH;
  localparam logic OUT_INACT = ~ACTIVE_HIGH;

  state_t           r_state;
  logic             r_out;
  logic             r_busy;
  logic             r_done;
  logic [7:0]       r_pcnt;
  logic [CNT_W-1:0] r_width;
  logic [CNT_W-1:0] r_hold;
  logic [CNT_W-1:0] r_hold_lat;
  logic             r_man_mode;
  logic             r_man_level;

  logic             w_wr;
  logic             w_wr_ctrl;
  logic             w_wr_stat;
  logic             w_start;
  logic             w_abort;
  logic             w_man_mode_nxt;
  logic             w_man_level_nxt;
  logic             w_go;
  logic             w_tc;
  logic             w_complete;
  logic             w_cnt_load;
  logic [CNT_W-1:0] w_cnt_val;
  logic [CNT_W-1:0] w_width_eff;
  logic             w_irq_en;
  logic             w_unused;

  assign w_wr      = i_chipselect & ~i_write_n;
  assign w_wr_ctrl = w_wr && (i_address == ADDR_CTRL);
  assign w_wr_stat = w_wr && (i_address == ADDR_STATUS);
  assign w_start   = w_wr_ctrl & i_writedata[CTRL_START];
  assign w_abort   = w_wr_ctrl & i_writedata[CTRL_ABORT];

  // Manual-mode values as they will be after this edge, so a CTRL write in
  // cycle N reaches the line in cycle N+1, same as a START.
  assign w_man_mode_nxt  = w_wr_ctrl ? i_writedata[CTRL_MAN_MODE]  : r_man_mode;
  assign w_man_level_nxt = w_wr_ctrl ? i_writedata[CTRL_MAN_LEVEL] : r_man_level;

  assign w_go        = (r_state == IDLE) && w_start && !w_abort && !w_man_mode_nxt;
  assign w_width_eff = (r_width == '0) ? CNT_W'(1) : r_width;

  assign w_complete = !w_abort && w_tc &&
                      (((r_state == ASSERT) && (r_hold_lat == '0)) || (r_state == HOLDOFF));

  assign w_cnt_load = w_go ||
                      ((r_state == ASSERT) && w_tc && !w_abort && (r_hold_lat != '0));
  assign w_cnt_val  = (r_state == IDLE) ? w_width_eff : r_hold_lat;

  ext_rst_seq_down_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_en       (r_busy),
    .o_tc       (w_tc)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_out       <= OUT_INACT;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pcnt      <= 8'd0;
      r_width     <= CNT_W'(DEFAULT_WIDTH);
      r_hold      <= '0;
      r_hold_lat  <= '0;
      r_man_mode  <= 1'b0;
      r_man_level <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_man_mode  <= i_writedata[CTRL_MAN_MODE];
        r_man_level <= i_writedata[CTRL_MAN_LEVEL];
      end
      if (w_wr && (i_address == ADDR_WIDTH))   r_width <= i_writedata[CNT_W-1:0];
      if (w_wr && (i_address == ADDR_HOLDOFF)) r_hold  <= i_writedata[CNT_W-1:0];

      // Completion beats a simultaneous W1C of done.
      if (w_complete) begin
        r_done <= 1'b1;
        r_pcnt <= r_pcnt + 8'd1;
      end else if (w_wr_stat && i_writedata[STAT_DONE]) begin
        r_done <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_go) begin
            r_state    <= ASSERT;
            r_busy     <= 1'b1;
            r_out      <= OUT_ACT;
            r_hold_lat <= r_hold;
          end else begin
            r_out <= (w_man_mode_nxt && w_man_level_nxt) ? OUT_ACT : OUT_INACT;
          end
        end
        ASSERT: begin
          if (w_abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_out   <= OUT_INACT;
          end else if (w_tc) begin
            r_out <= OUT_INACT;
            if (r_hold_lat == '0) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= HOLDOFF;
            end
          end
        end
        HOLDOFF: begin
          if (w_abort || w_tc) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_out   <= OUT_INACT;
        end
      endcase
    end
  end

`ifdef EXT_RST_SEQ_IRQ_EN
  logic r_irq_en;
  logic r_irq;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_stat) r_irq_en <= i_writedata[STAT_IRQ_EN];
      r_irq <= r_done & r_irq_en;
    end
  end

  assign o_irq    = r_irq;
  assign w_irq_en = r_irq_en;
`else
  assign w_irq_en = 1'b0;
`endif

  always_comb begin
    o_readdata = '0;
    case (i_address)
      ADDR_CTRL: begin
        o_readdata[CTRL_MAN_LEVEL] = r_man_level;
        o_readdata[CTRL_MAN_MODE]  = r_man_mode;
      end
      ADDR_WIDTH:   o_readdata = 32'(r_width);
      ADDR_HOLDOFF: o_readdata = 32'(r_hold);
      ADDR_STATUS: begin
        o_readdata[STAT_BUSY]                     = r_busy;
        o_readdata[STAT_DONE]                     = r_done;
        o_readdata[STAT_IRQ_EN]                   = w_irq_en;
        o_readdata[STAT_PCNT_MSB:STAT_PCNT_LSB]   = r_pcnt;
      end
      default: o_readdata = '0;
    endcase
  end

  assign o_out_port = r_out;
  assign o_busy     = r_busy;

  // Upper write-data bits have no destination.
  assign w_unused = ^i_writedata;

endmodule

// File: tb/tb_ext_rst_pulse_sequencer.sv
// tb_ext_rst_pulse_sequencer
//   Directed bench for ext_rst_pulse_sequencer. Two instances share the bus:
//   u_dut_hi (ACTIVE_HIGH=1, DEFAULT_WIDTH=100) and u_dut_lo (ACTIVE_HIGH=0,
//   DEFAULT_WIDTH=7). Inputs change on the falling edge, outputs are sampled
//   on the falling edge, so "cycle k" below is the k-th cycle after the write.
module tb_ext_rst_pulse_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] rd_hi, rd_lo;
  logic        out_hi, out_lo, busy_hi, busy_lo;
`ifdef EXT_RST_SEQ_IRQ_EN
  logic        irq_hi, irq_lo;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] rv;

  always #5 clk = ~clk;

  ext_rst_pulse_sequencer #(.CNT_W(16), .DEFAULT_WIDTH(100), .ACTIVE_HIGH(1'b1)) u_dut_hi (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_address    (address),
    .i_chipselect (chipselect),
    .i_write_n    (write_n),
    .i_writedata  (writedata),
    .o_readdata   (rd_hi),
    .o_out_port   (out_hi),
`ifdef EXT_RST_SEQ_IRQ_EN
    .o_irq        (irq_hi),
`endif
    .o_busy       (busy_hi)
  );

  ext_rst_pulse_sequencer #(.CNT_W(16), .DEFAULT_WIDTH(7), .ACTIVE_HIGH(1'b0)) u_dut_lo (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_address    (address),
    .i_chipselect (chipselect),
    .i_write_n    (write_n),
    .i_writedata  (writedata),
    .o_readdata   (rd_lo),
    .o_out_port   (out_lo),
`ifdef EXT_RST_SEQ_IRQ_EN
    .o_irq        (irq_lo),
`endif
    .o_busy       (busy_lo)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Called at a falling edge; the write is sampled on the following rising edge
  // and the task returns at the next falling edge (cycle 1 after the write).
  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d_hi);
    address = a;
    #1;
    d_hi = rd_hi;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check_val("rst_out_hi", 32'(out_hi), 32'd0);
    check_val("rst_out_lo", 32'(out_lo), 32'd1);
    check_val("rst_busy", 32'(busy_hi), 32'd0);
    bus_rd(2'd0, rv); check_val("rst_ctrl", rv, 32'd0);
    bus_rd(2'd1, rv); check_val("rst_width_hi", rv, 32'd100);
    check_val("rst_width_lo", rd_lo, 32'd7);
    bus_rd(2'd2, rv); check_val("rst_holdoff", rv, 32'd0);
    bus_rd(2'd3, rv); check_val("rst_status", rv, 32'd0);
`ifdef EXT_RST_SEQ_IRQ_EN
    check_val("rst_irq", 32'(irq_hi), 32'd0);
`endif

    // WIDTH=5 HOLDOFF=3: active cycles 1..5, busy 1..8
    bus_wr(2'd1, 32'd5);
    bus_wr(2'd2, 32'd3);
    bus_wr(2'd0, 32'h1);
    for (int k = 1; k <= 10; k++) begin
      check_val($sformatf("t1_out_c%0d", k), 32'(out_hi), 32'(k <= 5));
      check_val($sformatf("t1_busy_c%0d", k), 32'(busy_hi), 32'(k <= 8));
      if (k == 1) check_val("t1_out_lo_c1", 32'(out_lo), 32'd0);
      step();
    end
    bus_rd(2'd3, rv); check_val("t1_status", rv, 32'h0000_0102);

    // WIDTH=0 HOLDOFF=0: one active cycle, one busy cycle
    bus_wr(2'd3, 32'h2);
    bus_rd(2'd3, rv); check_val("t2_done_clr", rv, 32'h0000_0100);
    bus_wr(2'd1, 32'd0);
    bus_wr(2'd2, 32'd0);
    bus_wr(2'd0, 32'h1);
    for (int k = 1; k <= 3; k++) begin
      check_val($sformatf("t2_out_c%0d", k), 32'(out_hi), 32'(k == 1));
      check_val($sformatf("t2_busy_c%0d", k), 32'(busy_hi), 32'(k == 1));
      step();
    end
    bus_rd(2'd3, rv); check_val("t2_status", rv, 32'h0000_0202);

    // ABORT during cycle 2 of a 10-cycle pulse
    bus_wr(2'd3, 32'h2);
    bus_wr(2'd1, 32'd10);
    bus_wr(2'd0, 32'h1);
    check_val("t3_out_c1", 32'(out_hi), 32'd1);
    step();
    check_val("t3_out_c2", 32'(out_hi), 32'd1);
    bus_wr(2'd0, 32'h2);
    check_val("t3_out_c3", 32'(out_hi), 32'd0);
    check_val("t3_busy_c3", 32'(busy_hi), 32'd0);
    step();
    check_val("t3_out_c4", 32'(out_hi), 32'd0);
    bus_rd(2'd3, rv); check_val("t3_status", rv, 32'h0000_0200);

    // WIDTH=6 HOLDOFF=2; rewrite WIDTH/HOLDOFF and retry START mid-pulse
    bus_wr(2'd1, 32'd6);
    bus_wr(2'd2, 32'd2);
    bus_wr(2'd0, 32'h1);
    check_val("t4_out_c1", 32'(out_hi), 32'd1);
    bus_wr(2'd1, 32'd2);
    check_val("t4_out_c2", 32'(out_hi), 32'd1);
    bus_wr(2'd0, 32'h1);
    check_val("t4_out_c3", 32'(out_hi), 32'd1);
    bus_wr(2'd2, 32'd0);
    for (int k = 4; k <= 10; k++) begin
      check_val($sformatf("t4_out_c%0d", k), 32'(out_hi), 32'(k <= 6));
      check_val($sformatf("t4_busy_c%0d", k), 32'(busy_hi), 32'(k <= 8));
      step();
    end
    bus_rd(2'd3, rv); check_val("t4_status", rv, 32'h0000_0302);
    bus_rd(2'd1, rv); check_val("t4_width", rv, 32'd2);
    bus_wr(2'd0, 32'h1);
    for (int k = 1; k <= 3; k++) begin
      check_val($sformatf("t4b_out_c%0d", k), 32'(out_hi), 32'(k <= 2));
      check_val($sformatf("t4b_busy_c%0d", k), 32'(busy_hi), 32'(k <= 2));
      step();
    end
    bus_rd(2'd3, rv); check_val("t4b_status", rv, 32'h0000_0402);

    // Manual mode
    bus_wr(2'd0, 32'hC);
    check_val("t5_man_out_hi", 32'(out_hi), 32'd1);
    check_val("t5_man_out_lo", 32'(out_lo), 32'd0);
    check_val("t5_man_busy", 32'(busy_hi), 32'd0);
    bus_wr(2'd0, 32'hD);
    check_val("t5_start_busy_c1", 32'(busy_hi), 32'd0);
    step();
    check_val("t5_start_busy_c2", 32'(busy_hi), 32'd0);
    check_val("t5_start_out", 32'(out_hi), 32'd1);
    bus_rd(2'd0, rv); check_val("t5_ctrl_rd", rv, 32'hC);
    bus_wr(2'd0, 32'h8);
    check_val("t5_man_low", 32'(out_hi), 32'd0);
    bus_wr(2'd0, 32'h0);
    check_val("t5_man_off", 32'(out_hi), 32'd0);

    // START+ABORT in one write: no pulse
    bus_wr(2'd0, 32'h3);
    check_val("t6_busy_c1", 32'(busy_hi), 32'd0);
    check_val("t6_out_c1", 32'(out_hi), 32'd0);
    step();
    bus_rd(2'd3, rv); check_val("t6_status", rv, 32'h0000_0402);

    // MAN_MODE set mid-pulse leaves the running pulse alone (WIDTH=2, HOLDOFF=0)
    bus_wr(2'd0, 32'h1);
    bus_wr(2'd0, 32'h8);
    check_val("t7_out_c2", 32'(out_hi), 32'd1);
    check_val("t7_busy_c2", 32'(busy_hi), 32'd1);
    step();
    check_val("t7_out_c3", 32'(out_hi), 32'd0);
    check_val("t7_busy_c3", 32'(busy_hi), 32'd0);
    bus_wr(2'd0, 32'h0);
    bus_rd(2'd3, rv); check_val("t7_status", rv, 32'h0000_0502);

`ifdef EXT_RST_SEQ_IRQ_EN
    check_val("t8_irq_off", 32'(irq_hi), 32'd0);
    bus_wr(2'd3, 32'h4);
    step();
    check_val("t8_irq_on", 32'(irq_hi), 32'd1);
    bus_rd(2'd3, rv); check_val("t8_status_en", rv, 32'h0000_0506);
    bus_wr(2'd3, 32'h6);
    step();
    check_val("t8_irq_clr", 32'(irq_hi), 32'd0);
    bus_wr(2'd3, 32'h0);
    bus_rd(2'd3, rv); check_val("t8_status_dis", rv, 32'h0000_0500);
`else
    bus_wr(2'd3, 32'h4);
    bus_rd(2'd3, rv); check_val("t8_irq_en_absent", rv, 32'h0000_0502);
    bus_wr(2'd3, 32'h2);
    bus_rd(2'd3, rv); check_val("t8_done_clr", rv, 32'h0000_0500);
`endif

    // Reset in the middle of a pulse
    bus_wr(2'd1, 32'd10);
    bus_wr(2'd0, 32'h1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_val("t9_out_hi", 32'(out_hi), 32'd0);
    check_val("t9_out_lo", 32'(out_lo), 32'd1);
    check_val("t9_busy", 32'(busy_hi), 32'd0);
    bus_rd(2'd3, rv); check_val("t9_status", rv, 32'd0);
    bus_rd(2'd1, rv); check_val("t9_width", rv, 32'd100);

    // 256 completed pulses wrap pulse_cnt back to 0
    bus_wr(2'd1, 32'd0);
    for (int i = 0; i < 255; i++) begin
      bus_wr(2'd0, 32'h1);
      step();
    end
    bus_rd(2'd3, rv); check_val("t10_pcnt_255", rv, 32'h0000_FF02);
    bus_wr(2'd0, 32'h1);
    step();
    bus_rd(2'd3, rv); check_val("t10_pcnt_wrap", rv, 32'h0000_0002);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
